uart_rx: RTL and testbench

// - Asynchronous serial receiver; downstream peer of the uart transmitter on the serial line.
// - Oversamples rx_wire, recovers start/data/stop framing LSB-first, presents a parallel word via a valid/ack handshake.
// - Flags framing errors and overruns; optional parity checking.

---
 rtl/uart_rx.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/stop framing LSB-first, with a valid/ack output handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error output.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD       = 9600,
  parameter int SYS_CLK    = 12000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 rx_wire,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 framing_error,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 overrun
);

  // state   | meaning
  // IDLE    | line idle; waiting for a falling edge, counters cleared
  // START   | half a bit in; confirm the start bit is still low
  // DATA    | sampling data bits at bit centre, LSB first
  // PARITY  | sampling the even-parity bit (parity build only)
  // STOP    | sampling the stop bit
  // BRK     | stop bit was low; wait for the line to return high

  localparam int DIV    = SYS_CLK / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] HALF_LOAD = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LOAD = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BRK    = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 tick;
  logic                 sample;
  logic                 deliver_q;

  logic load_half, load_full, bit_clr, shift_en;
  logic deliver_set, ferr_set, perr_set;

  assign rx_s   = sync_q[1];
  assign tick   = enable && (state != S_IDLE) && (div_cnt == DIV_LAST);
  assign sample = tick && (tick_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_wire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_half   = 1'b0;
    load_full   = 1'b0;
    bit_clr     = 1'b0;
    shift_en    = 1'b0;
    deliver_set = 1'b0;
    ferr_set    = 1'b0;
    perr_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt = S_START;
          load_half = 1'b1;
        end
      end
      S_START: begin
        if (sample) begin
          if (!rx_s) begin
            state_nxt = S_DATA;
            load_full = 1'b1;
            bit_clr   = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample) begin
          perr_set  = (^shift_reg) ^ rx_s;
          load_full = 1'b1;
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (sample) begin
          if (rx_s) begin
            deliver_set = 1'b1;
            state_nxt   = S_IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = S_BRK;
          end
        end
      end
      S_BRK: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!enable) begin
      state_nxt   = S_IDLE;
      load_half   = 1'b0;
      load_full   = 1'b0;
      bit_clr     = 1'b0;
      shift_en    = 1'b0;
      deliver_set = 1'b0;
      ferr_set    = 1'b0;
      perr_set    = 1'b0;
    end
  end

  // Prescaler restarts at every start edge so the bit-centre phase follows the incoming frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             div_cnt <= '0;
    else if (!enable || state == S_IDLE)    div_cnt <= '0;
    else if (tick)                          div_cnt <= '0;
    else                                    div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tick_cnt <= '0;
    else if (load_half) tick_cnt <= HALF_LOAD;
    else if (load_full) tick_cnt <= FULL_LOAD;
    else if (tick)      tick_cnt <= tick_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)      shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
  end

  // shift_reg is stable in IDLE, so the word is still intact on the cycle after the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deliver_q     <= 1'b0;
      rx_data       <= '0;
      data_valid    <= 1'b0;
      overrun       <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      deliver_q     <= deliver_set;
      framing_error <= ferr_set;
      if (deliver_q) begin
        if (!data_valid || data_ack) begin
          rx_data    <= shift_reg;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_error <= 1'b0;
    else        parity_error <= perr_set;
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (DIV=78, 1248 clk per bit).
// Parity frames are exercised only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int BIT       = 1248;
  localparam int STOP_HOLD = 700;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       rx_wire;
  logic [7:0] rx_data;
  logic       data_valid;
  logic       data_ack;
  logic       framing_error;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  int checks   = 0;
  int failures = 0;

  int ferr_cycles  = 0;
  int perr_cycles  = 0;
  int valid_rises  = 0;
  logic valid_d    = 1'b0;

  int ferr_base;
  int rise_base;

  uart_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .rx_wire       (rx_wire),
    .rx_data       (rx_data),
    .data_valid    (data_valid),
    .data_ack      (data_ack),
    .framing_error (framing_error),
`ifdef UART_RX_PARITY_EN
    .parity_error  (parity_error),
`endif
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and delivery event counters
  always @(posedge clk) begin
    if (framing_error) ferr_cycles++;
`ifdef UART_RX_PARITY_EN
    if (parity_error) perr_cycles++;
`endif
    if (data_valid && !valid_d) valid_rises++;
    valid_d = data_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    rx_wire = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    send_bit(^d, BIT);
`endif
    send_bit(stop_b, STOP_HOLD);
    rx_wire = 1'b1;
    repeat (20) @(negedge clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_parity_frame(input logic [7:0] d, input logic par);
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
    send_bit(par, BIT);
    send_bit(1'b1, STOP_HOLD);
    repeat (20) @(negedge clk);
  endtask
`endif

  task automatic ack_pulse();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    rx_wire  = 1'b1;
    data_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_valid", data_valid, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_ferr", framing_error, 1'b0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // Start glitch shorter than half a bit
    send_bit(1'b0, 3 * 78);
    send_bit(1'b1, BIT);
    check("glitch_valid", data_valid, 1'b0);
    check("glitch_ferr", ferr_cycles, 0);
    check("glitch_rises", valid_rises, 0);

    send_frame(8'hA5, 1'b1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid", data_valid, 1'b1);
    check("a5_overrun", overrun, 1'b0);
    check("a5_ferr", ferr_cycles, 0);
    check("a5_rises", valid_rises, 1);
    ack_pulse();
    check("a5_ack_valid", data_valid, 1'b0);
    ack_pulse();
    check("idle_ack_valid", data_valid, 1'b0);
    check("idle_ack_overrun", overrun, 1'b0);

    ferr_base = ferr_cycles;
    send_frame(8'h3C, 1'b0);
    check("3c_ferr_pulse", ferr_cycles - ferr_base, 1);
    check("3c_valid", data_valid, 1'b0);
    check("3c_data_kept", rx_data, 8'hA5);
    repeat (200) @(negedge clk);
    send_frame(8'h11, 1'b1);
    check("11_data", rx_data, 8'h11);
    check("11_valid", data_valid, 1'b1);
    ack_pulse();

    send_frame(8'h12, 1'b1);
    check("12_data", rx_data, 8'h12);
    check("12_overrun", overrun, 1'b0);
    send_frame(8'h34, 1'b1);
    check("34_data_kept", rx_data, 8'h12);
    check("34_overrun", overrun, 1'b1);
    check("34_valid", data_valid, 1'b1);
    ack_pulse();
    check("ovr_ack_valid", data_valid, 1'b0);
    check("ovr_ack_overrun", overrun, 1'b0);

    // Reset in the middle of the data bits of 0xFF
    rise_base = valid_rises;
    ferr_base = ferr_cycles;
    send_bit(1'b0, BIT);
    send_bit(1'b1, 3 * BIT);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_valid", data_valid, 1'b0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    check("5a_data", rx_data, 8'h5A);
    check("5a_valid", data_valid, 1'b1);
    check("5a_rises", valid_rises - rise_base, 1);
    check("5a_ferr", ferr_cycles - ferr_base, 0);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    send_parity_frame(8'h03, 1'b1);
    check("par_bad_pulse", perr_cycles, 1);
    check("par_bad_data", rx_data, 8'h03);
    check("par_bad_valid", data_valid, 1'b1);
    ack_pulse();
    send_parity_frame(8'h03, 1'b0);
    check("par_ok_pulse", perr_cycles, 1);
    check("par_ok_valid", data_valid, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
